// File: rtl/ws2812_receiver.sv
// WS2812-style single-wire NRZ pixel-stream receiver.
// Measures each high pulse on din to decide whether it carries a 0 or a 1.
// It assembles 24-bit pixels, MSB first, and tracks each pixel's index within the frame.
// A long low gap latches the frame. Malformed traffic raises a one-cycle error strobe.
module ws2812_receiver #(
    parameter int T1H_MIN_CYCLES  = 6,
    parameter int HIGH_MAX_CYCLES = 14,
    parameter int RESET_CYCLES    = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic [5:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        err,
    output logic        busy
);
    localparam int HCW = $clog2(HIGH_MAX_CYCLES + 2);
    localparam int LCW = $clog2(RESET_CYCLES + 1);
    localparam logic [HCW-1:0] HIGH_SAT = HCW'(HIGH_MAX_CYCLES + 1);
    localparam logic [HCW-1:0] HIGH_MAX = HCW'(HIGH_MAX_CYCLES);
    localparam logic [HCW-1:0] T1H_MIN  = HCW'(T1H_MIN_CYCLES);
    localparam logic [LCW-1:0] LOW_SAT  = LCW'(RESET_CYCLES);

    typedef enum logic [1:0] {SYNC, WAIT, HIGH} state_t;

    logic           sync1_q, din_s_q, din_d_q;
    logic           rise, fall, latch;
    logic [HCW-1:0] high_cnt_q, high_cnt_d;
    logic [LCW-1:0] low_cnt_q, low_cnt_d;

    state_t         state_q;
    logic [22:0]    shreg_q;
    logic [4:0]     bit_cnt_q;
    logic [5:0]     pix_cnt_q;
    logic           wrapped_q;
    logic [23:0]    pixel_data_q;
    logic [5:0]     pixel_index_q;
    logic           pixel_valid_q, frame_done_q, err_q, busy_q;

    logic           bit_val;
    logic [23:0]    word;

    assign rise    = din_s_q & ~din_d_q;
    assign fall    = ~din_s_q & din_d_q;
    // Fires only on the single cycle the low counter reaches saturation.
    assign latch   = ~din_s_q && (low_cnt_q == LOW_SAT - 1'b1);
    assign bit_val = (high_cnt_q >= T1H_MIN);
    assign word    = {shreg_q, bit_val};

    assign pixel_data  = pixel_data_q;
    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign busy        = busy_q;

    // Two-flop synchronizer for the asynchronous line plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            din_s_q <= 1'b0;
            din_d_q <= 1'b0;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
            din_d_q <= din_s_q;
        end
    end

    // Pulse-width counters. The rise cycle counts as the first high clock,
    // so an N-clock pulse reads N on its fall event.
    always_comb begin
        high_cnt_d = high_cnt_q;
        if (rise) begin
            high_cnt_d = HCW'(1);
        end else if (din_s_q && high_cnt_q != HIGH_SAT) begin
            high_cnt_d = high_cnt_q + 1'b1;
        end
        low_cnt_d = low_cnt_q;
        if (din_s_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_SAT) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
        end
    end

    // Decoder FSM: bit assembly, pixel/frame bookkeeping and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SYNC;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            wrapped_q     <= 1'b0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (latch) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (rise) begin
                        state_q <= HIGH;
                    end else if (latch) begin
                        // A partial pixel at the latch is an error.
                        // Frame_done can fire in the same cycle.
                        if (bit_cnt_q != 5'd0) begin
                            err_q <= 1'b1;
                        end
                        if (pix_cnt_q != 6'd0 || wrapped_q) begin
                            frame_done_q <= 1'b1;
                        end
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        pix_cnt_q <= '0;
                        wrapped_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                HIGH: begin
                    if (high_cnt_d > HIGH_MAX) begin
                        // An over-long pulse discards the whole frame. Resync needs a full latch gap.
                        err_q     <= 1'b1;
                        state_q   <= SYNC;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        pix_cnt_q <= '0;
                        wrapped_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (fall) begin
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                        shreg_q <= word[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            pixel_data_q  <= word;
                            pixel_index_q <= pix_cnt_q;
                            pixel_valid_q <= 1'b1;
                            pix_cnt_q     <= pix_cnt_q + 6'd1;
                            bit_cnt_q     <= '0;
                            if (pix_cnt_q == 6'd63) begin
                                wrapped_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_receiver.sv
// Testbench for ws2812_receiver. A scoreboard queue holds the expected pixels
// and the cycle on which each one is due. Scenario tasks check strobe counts
// and output levels.
module tb_ws2812_receiver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b1;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid, frame_done, err, busy;

    typedef struct packed {
        logic [23:0] d;
        logic [5:0]  i;
        logic [31:0] due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   fall_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pv_cnt = 0, fd_cnt = 0, err_cnt = 0, err_cyc = 0;

    ws2812_receiver dut (
        .clk(clk), .reset(reset), .din(din),
        .pixel_data(pixel_data), .pixel_index(pixel_index),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pixel_valid strobe must match the next expected pixel and its due cycle.
    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            pv_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got data=%h idx=%0d at cyc %0d, none expected",
                         pixel_data, pixel_index, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pixel_data !== e.d || pixel_index !== e.i || cyc !== int'(e.due)) begin
                    n_fail++;
                    $display("FAIL pixel: got data=%h idx=%0d cyc=%0d, expected data=%h idx=%0d cyc=%0d",
                             pixel_data, pixel_index, cyc, e.d, e.i, e.due);
                end
            end
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(input int hi);
        din = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        din = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic send_bit(input logic b);
        send_pulse(b ? 9 : 4);
        idle(b ? 6 : 11);
    endtask

    task automatic send_pixel(input logic [23:0] w, input logic [5:0] idx, input bit expect_it);
        for (int i = 23; i > 0; i--) send_bit(w[i]);
        send_pulse(w[0] ? 9 : 4);
        if (expect_it) exp_q.push_back({w, idx, 32'(fall_cyc + 3)});
        idle(w[0] ? 6 : 11);
    endtask

    task automatic check_counts(input string name, input int pv0, input int fd0, input int er0,
                                input int dpv, input int dfd, input int der);
        n_checks++;
        if (pv_cnt - pv0 !== dpv || fd_cnt - fd0 !== dfd || err_cnt - er0 !== der) begin
            n_fail++;
            $display("FAIL %s: strobes pv/fd/err got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     name, pv_cnt - pv0, fd_cnt - fd0, err_cnt - er0, dpv, dfd, der);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_queue: %0d expected pixels never arrived, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        int pv0, fd0, er0;
        reset = 1'b1;
        din = 1'b1;
        idle(3);
        n_checks++;
        if ({pixel_data, pixel_index, pixel_valid, frame_done, err, busy} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h idx=%0d pv=%b fd=%b err=%b busy=%b, expected all 0",
                     pixel_data, pixel_index, pixel_valid, frame_done, err, busy);
        end
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        reset = 1'b0;
        idle(2000);
        check_counts("held_high", pv0, fd0, er0, 0, 0, 0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_high_busy: got %b, expected 0", busy);
        end
        din = 1'b0;
        idle(605);
        check_counts("sync_gap", pv0, fd0, er0, 0, 0, 0);
    endtask

    task automatic test_single_pixel;
        int pv0, fd0, er0;
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_bit(1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_bit: got %b, expected 1", busy);
        end
        for (int i = 22; i > 0; i--) send_bit(24'h00FF55 >> i);
        send_pulse(9);
        exp_q.push_back({24'h00FF55, 6'd0, 32'(fall_cyc + 3)});
        idle(6);
        idle(600);
        check_counts("single_pixel", pv0, fd0, er0, 1, 1, 0);
        n_checks++;
        if (busy !== 1'b0 || pixel_data !== 24'h00FF55 || pixel_index !== 6'd0) begin
            n_fail++;
            $display("FAIL single_hold: got busy=%b data=%h idx=%0d, expected busy=0 data=00ff55 idx=0",
                     busy, pixel_data, pixel_index);
        end
    endtask

    task automatic test_back_to_back;
        int pv0, fd0, er0;
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_pixel(24'h123456, 6'd0, 1'b1);
        send_pixel(24'hABCDEF, 6'd1, 1'b1);
        send_pixel(24'h000001, 6'd2, 1'b1);
        idle(600);
        check_counts("back_to_back", pv0, fd0, er0, 3, 1, 0);
    endtask

    task automatic test_boundary;
        int pv0, fd0, er0, r;
        logic [23:0] base, w;
        int hi;
        base = 24'h35A5C3;
        w = {3'b011, base[20:0]};
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        for (int i = 23; i >= 0; i--) begin
            hi = (i == 23) ? 5 : (i == 22) ? 6 : (i == 21) ? 14 : (base[i] ? 9 : 4);
            send_pulse(hi);
            if (i == 0) exp_q.push_back({w, 6'd0, 32'(fall_cyc + 3)});
            idle(6);
        end
        idle(600);
        check_counts("widths_5_6_14", pv0, fd0, er0, 1, 1, 0);

        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_bit(1'b1);
        r = cyc;
        send_pulse(15);
        idle(6);
        n_checks++;
        if (err_cnt - er0 !== 1 || err_cyc !== r + 17) begin
            n_fail++;
            $display("FAIL width_15_err: got %0d err at cyc %0d, expected 1 at cyc %0d",
                     err_cnt - er0, err_cyc, r + 17);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL width_15_busy: got %b, expected 0", busy);
        end
        send_pixel(24'hFFFFFF, 6'd0, 1'b0);
        idle(600);
        check_counts("after_err_ignored", pv0, fd0, er0, 0, 0, 1);
    endtask

    task automatic test_partial;
        int pv0, fd0, er0;
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        idle(600);
        check_counts("partial", pv0, fd0, er0, 0, 0, 1);
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_pixel(24'h5A5A5A, 6'd0, 1'b1);
        idle(600);
        check_counts("after_partial", pv0, fd0, er0, 1, 1, 0);
    endtask

    task automatic test_wrap;
        int pv0, fd0, er0;
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        for (int k = 0; k < 65; k++) send_pixel(24'($urandom), 6'(k % 64), 1'b1);
        idle(600);
        check_counts("wrap65", pv0, fd0, er0, 65, 1, 0);
    endtask

    task automatic test_reset_mid_frame;
        int pv0, fd0, er0;
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_pixel(24'hC0FFEE, 6'd0, 1'b1);
        send_pixel(24'hBEEF01, 6'd1, 1'b1);
        for (int i = 23; i >= 12; i--) send_bit(i[0]);
        reset = 1'b1;
        idle(1);
        n_checks++;
        if ({pixel_data, pixel_index, pixel_valid, frame_done, err, busy} !== 34'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%h idx=%0d pv=%b fd=%b err=%b busy=%b, expected all 0",
                     pixel_data, pixel_index, pixel_valid, frame_done, err, busy);
        end
        reset = 1'b0;
        idle(2);
        check_counts("midreset", pv0, fd0, er0, 2, 0, 0);
        pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
        send_pixel(24'h777777, 6'd0, 1'b0);
        idle(600);
        check_counts("midreset_needs_gap", pv0, fd0, er0, 0, 0, 0);
        send_pixel(24'h0F0F0F, 6'd0, 1'b1);
        idle(600);
        check_counts("midreset_recover", pv0, fd0, er0, 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_boundary();
        test_partial();
        test_wrap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
